rf_ctrl: RTL and testbench
==========================

RF_CTRL -- requirements
Module: rf_ctrl

Interface
REQ-001 Param RF_ADDRESS_WIDTH, default 5: register address width (AW); 2^AW registers.
REQ-002 Param DATA_WIDTH, default 16: register data width (DW).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 syn_rst  in  1  reset, synchronous, active-high.
REQ-005 init_done  out  1  register-file zero sweep complete; controller in RUN.
REQ-006 rd_req_valid  in  1  operand read request valid.
REQ-007 rd_req_ready  out  1  read request accepted on valid&&ready at edge.
REQ-008 rd_src1 / rd_src2  in  AW each  source register addresses.
REQ-009 rsp_valid  out  1  operand response valid.
REQ-010 rsp_ready  in  1  response consumed on valid&&ready at edge.
REQ-011 rsp_op1 / rsp_op2  out  DW each  operand values.
REQ-012 wb_valid  in  1  writeback request valid.
REQ-013 wb_ready  out  1  writeback accepted on valid&&ready at edge.
REQ-014 wb_addr  in  AW; wb_data  in  DW  writeback destination and value.
REQ-015 we  out  1; rd  out  AW; data_in  out  DW  register-file write port, written by rf at rising edge when we=1.
REQ-016 rs1 / rs2  out  AW each; Qs1 / Qs2  in  DW each  register-file read port; Qs combinational from rs, pre-write contents.

Function
REQ-017 FSM states INIT and RUN only; INIT entered by reset, RUN entered after final sweep write; no other transition.
REQ-018 INIT: AW-bit counter from 0; each cycle we=1, rd=counter, data_in=0; 2^AW consecutive writes (0..2^AW-1), no gaps.
REQ-019 Cycle after the write of address 2^AW-1: state RUN, init_done=1, we=0.
REQ-020 INIT: rd_req_ready=0, wb_ready=0, rs1=rs2=0, rsp_valid=0.
REQ-021 RUN: wb_ready=1 every cycle (writeback never stalled).
REQ-022 Accepted writeback registered: next cycle we=1, rd=wb_addr, data_in=wb_data (pending write), then rf commits at following edge; we=0 in any cycle with no pending write.
REQ-023 Writeback to address 0 accepted but dropped: we stays 0.
REQ-024 RUN: rs1=rd_src1, rs2=rd_src2 combinationally every cycle.
REQ-025 rd_req_ready = init_done && (!rsp_valid || rsp_ready); same-edge drain and accept allowed.
REQ-026 On read accept, per operand, captured value priority: address 0 -> 0; else same-cycle accepted writeback with wb_addr match -> wb_data; else pending write (we=1, rd match) -> data_in; else Qs.
REQ-027 Read latency 1: rsp_valid=1 and rsp_op1/rsp_op2 valid the cycle after accept.
REQ-028 rsp_valid=1 && rsp_ready=0: rsp_valid, rsp_op1, rsp_op2 held stable; no new accept.
REQ-029 rsp_ready=1 with no new accept: rsp_valid falls next cycle; rsp_op values may hold.
REQ-030 Program order: writeback accepted in same cycle as read is ordered before the read; writebacks to same address in consecutive cycles each commit, last wins.

Reset
REQ-031 syn_rst=1 at an edge forces next cycle: state INIT, counter 0, init_done=0, we=0, rd=0, data_in=0, rs1=rs2=0, rsp_valid=0, rsp_op1=rsp_op2=0, rd_req_ready=0, wb_ready=0.
REQ-032 Reset mid-operation discards pending write and held response; sweep restarts at address 0 in the first cycle with syn_rst=0.
REQ-033 Held syn_rst keeps all outputs at reset values; no rf writes during reset.

Verification
REQ-034 Reset 1 cycle, release -> 32 cycles we=1, rd=0..31, data_in=0; init_done=1 on cycle 33; both readies 0 before then.
REQ-035 wb r5=0x1234, 3 idle cycles, read src1=5 src2=0 -> next cycle rsp_valid=1, rsp_op1=0x1234, rsp_op2=0x0000.
REQ-036 Same cycle wb r7=0xBEEF and read src1=7 -> rsp_op1=0xBEEF; repeat read of r7 next cycle (pending write) -> rsp_op1=0xBEEF.
REQ-037 rsp_ready=0 for 4 cycles with rd_req_valid=1 -> rsp stable, rd_req_ready=0; rsp_ready=1 -> drain and new accept same edge, new rsp next cycle.
REQ-038 wb r0=0xFFFF -> we stays 0; read src1=0 -> rsp_op1=0x0000.
REQ-039 syn_rst while rsp_valid=1 and we=1 -> next cycle rsp_valid=0, we=0; after release sweep restarts at rd=0.

Source files
------------

// File: rtl/rf_ctrl.sv
// rf_ctrl -- register-file controller.
//
// After reset the controller sweeps zeros into every register of an external
// register file (INIT), then enters RUN, where it serves operand reads and
// writebacks with forwarding so that every read sees program-ordered data.
//
// Ports
//   clk, syn_rst                  clock, synchronous active-high reset
//   init_done                     zero sweep finished, controller in RUN
//   rd_req_valid/rd_req_ready     operand read request handshake
//   rd_src1, rd_src2              source register addresses
//   rsp_valid/rsp_ready           operand response handshake
//   rsp_op1, rsp_op2              operand values (one cycle after accept)
//   wb_valid/wb_ready             writeback handshake (never stalled in RUN)
//   wb_addr, wb_data              writeback destination and value
//   we, rd, data_in               register-file write port (registered)
//   rs1, rs2 / Qs1, Qs2           register-file read port (Qs combinational)
module rf_ctrl #(
  parameter int RF_ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH       = 16
) (
  input  logic                        clk,
  input  logic                        syn_rst,
  output logic                        init_done,
  input  logic                        rd_req_valid,
  output logic                        rd_req_ready,
  input  logic [RF_ADDRESS_WIDTH-1:0] rd_src1,
  input  logic [RF_ADDRESS_WIDTH-1:0] rd_src2,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_op1,
  output logic [DATA_WIDTH-1:0]       rsp_op2,
  input  logic                        wb_valid,
  output logic                        wb_ready,
  input  logic [RF_ADDRESS_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  output logic                        we,
  output logic [RF_ADDRESS_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0]       data_in,
  output logic [RF_ADDRESS_WIDTH-1:0] rs1,
  output logic [RF_ADDRESS_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0]       Qs1,
  input  logic [DATA_WIDTH-1:0]       Qs2
);

  localparam logic [RF_ADDRESS_WIDTH-1:0] ADDR_ZERO = {RF_ADDRESS_WIDTH{1'b0}};
  localparam logic [RF_ADDRESS_WIDTH-1:0] ADDR_MAX  = {RF_ADDRESS_WIDTH{1'b1}};
  localparam logic [RF_ADDRESS_WIDTH-1:0] ADDR_ONE  =
    {{(RF_ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]       DATA_ZERO = {DATA_WIDTH{1'b0}};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [RF_ADDRESS_WIDTH-1:0]   cnt_q, cnt_d;
  logic                          we_q, we_d;
  logic [RF_ADDRESS_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]         data_in_q, data_in_d;
  logic                          rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]         rsp_op1_q, rsp_op1_d;
  logic [DATA_WIDTH-1:0]         rsp_op2_q, rsp_op2_d;

  logic                          run_s;
  logic                          rd_acc_s;
  logic                          wb_acc_s;

  // Operand selection in program order: r0 is hard zero, then the writeback
  // accepted this very cycle (older than the read), then the write still
  // sitting on the rf port (not yet visible on Qs), then the rf contents.
  function automatic logic [DATA_WIDTH-1:0] fwd_operand(
    input logic [RF_ADDRESS_WIDTH-1:0] src,
    input logic [DATA_WIDTH-1:0]       qs,
    input logic                        wb_hit_en,
    input logic [RF_ADDRESS_WIDTH-1:0] wb_a,
    input logic [DATA_WIDTH-1:0]       wb_d,
    input logic                        pend_we,
    input logic [RF_ADDRESS_WIDTH-1:0] pend_a,
    input logic [DATA_WIDTH-1:0]       pend_d
  );
    logic [DATA_WIDTH-1:0] val;
    if (src == ADDR_ZERO) begin
      val = DATA_ZERO;
    end else if (wb_hit_en && (wb_a == src)) begin
      val = wb_d;
    end else if (pend_we && (pend_a == src)) begin
      val = pend_d;
    end else begin
      val = qs;
    end
    return val;
  endfunction

  assign run_s        = (state_q == ST_RUN);
  assign init_done    = run_s;
  assign wb_ready     = run_s;
  assign rd_req_ready = run_s && (!rsp_valid_q || rsp_ready);
  assign rd_acc_s     = rd_req_valid && rd_req_ready;
  assign wb_acc_s     = wb_valid && wb_ready;
  assign rs1          = run_s ? rd_src1 : ADDR_ZERO;
  assign rs2          = run_s ? rd_src2 : ADDR_ZERO;
  assign we           = we_q;
  assign rd           = rd_q;
  assign data_in      = data_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_op1      = rsp_op1_q;
  assign rsp_op2      = rsp_op2_q;

  // Next-state logic: zero sweep in INIT, writeback/read servicing in RUN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = 1'b0;
    rd_d        = rd_q;
    data_in_d   = data_in_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op1_d   = rsp_op1_q;
    rsp_op2_d   = rsp_op2_q;
    case (state_q)
      ST_INIT: begin
        // The last sweep write is on the port this cycle; leave INIT once it
        // commits rather than when the counter wraps, so no gap or extra write.
        if (we_q && (rd_q == ADDR_MAX)) begin
          state_d = ST_RUN;
          we_d    = 1'b0;
        end else begin
          we_d      = 1'b1;
          rd_d      = cnt_q;
          data_in_d = DATA_ZERO;
          cnt_d     = cnt_q + ADDR_ONE;
        end
      end
      ST_RUN: begin
        // Writes to r0 are accepted but never reach the rf.
        if (wb_acc_s && (wb_addr != ADDR_ZERO)) begin
          we_d      = 1'b1;
          rd_d      = wb_addr;
          data_in_d = wb_data;
        end else begin
          we_d = 1'b0;
        end
        if (rd_acc_s) begin
          rsp_valid_d = 1'b1;
          rsp_op1_d   = fwd_operand(rd_src1, Qs1, wb_acc_s, wb_addr, wb_data,
                                    we_q, rd_q, data_in_q);
          rsp_op2_d   = fwd_operand(rd_src2, Qs2, wb_acc_s, wb_addr, wb_data,
                                    we_q, rd_q, data_in_q);
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
        end else begin
          rsp_valid_d = rsp_valid_q;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = ADDR_ZERO;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (syn_rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= ADDR_ZERO;
      we_q        <= 1'b0;
      rd_q        <= ADDR_ZERO;
      data_in_q   <= DATA_ZERO;
      rsp_valid_q <= 1'b0;
      rsp_op1_q   <= DATA_ZERO;
      rsp_op2_q   <= DATA_ZERO;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      rd_q        <= rd_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op1_q   <= rsp_op1_d;
      rsp_op2_q   <= rsp_op2_d;
    end
  end

endmodule

// File: tb/tb_rf_ctrl.sv
// tb_rf_ctrl -- self-checking bench for rf_ctrl.
//
// Holds a behavioural register file on the rf ports (seeded with garbage so
// the zero sweep is observable) and an architectural reference array updated
// in program order. Expected responses are pushed to a queue when a read is
// accepted and compared when the DUT presents them.
module tb_rf_ctrl;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NREG = 32;

  logic          clk;
  logic          syn_rst;
  logic          init_done;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_src1, rd_src2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_op1, rsp_op2;
  logic          wb_valid;
  logic          wb_ready;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          we;
  logic [AW-1:0] rd;
  logic [DW-1:0] data_in;
  logic [AW-1:0] rs1, rs2;
  logic [DW-1:0] qs1, qs2;

  logic [DW-1:0] rf_mem [NREG];
  logic          scramble;

  logic [DW-1:0] ref_rf [NREG];
  logic [2*DW-1:0] sb [$];
  logic          run_m;
  int            checks;
  int            errors;

  rf_ctrl #(.RF_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .syn_rst(syn_rst), .init_done(init_done),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_src1(rd_src1), .rd_src2(rd_src2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op1(rsp_op1), .rsp_op2(rsp_op2),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .we(we), .rd(rd), .data_in(data_in),
    .rs1(rs1), .rs2(rs2), .Qs1(qs1), .Qs2(qs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write at rising edge.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= 16'h5A00 | 16'(i);
    end else if (we) begin
      rf_mem[rd] <= data_in;
    end
  end
  assign qs1 = rf_mem[rs1];
  assign qs2 = rf_mem[rs2];

  task automatic check_eq(input string tag, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rd_req_valid = 1'b0;
    wb_valid     = 1'b0;
    rsp_ready    = 1'b1;
  endtask

  // One RUN-mode cycle: inputs already driven; check handshake outputs,
  // advance the reference model, cross the edge, check registered outputs.
  task automatic step();
    logic exp_rdy;
    logic exp_we;
    #1;
    exp_rdy = run_m && ((sb.size() == 0) || rsp_ready);
    check_eq("rd_req_ready", rd_req_ready, exp_rdy);
    check_eq("wb_ready", wb_ready, run_m);
    check_eq("rs1", rs1, run_m ? rd_src1 : 5'd0);
    exp_we = run_m && wb_valid && (wb_addr != 5'd0);
    if (rsp_ready && (sb.size() > 0)) void'(sb.pop_front());
    if (exp_we) ref_rf[wb_addr] = wb_data;
    if (rd_req_valid && exp_rdy) sb.push_back({ref_rf[rd_src1], ref_rf[rd_src2]});
    @(posedge clk);
    #1;
    check_eq("we", we, exp_we);
    if (exp_we) begin
      check_eq("wb_rd", rd, wb_addr);
      check_eq("wb_data_in", data_in, wb_data);
    end
    if (sb.size() > 0) begin
      check_eq("rsp_valid", rsp_valid, 1'b1);
      check_eq("rsp_op1", rsp_op1, sb[0][2*DW-1:DW]);
      check_eq("rsp_op2", rsp_op2, sb[0][DW-1:0]);
    end else begin
      check_eq("rsp_valid", rsp_valid, 1'b0);
    end
  endtask

  task automatic rd_req(input logic [AW-1:0] s1, input logic [AW-1:0] s2);
    rd_req_valid = 1'b1;
    rd_src1      = s1;
    rd_src2      = s2;
  endtask

  task automatic wb_req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  // Called in the first cycle after reset release: expects 32 back-to-back
  // zero writes while requests are held active and ignored, then init_done.
  task automatic sweep_check();
    rd_req(5'd9, 5'd10);
    wb_req(5'd3, 16'hAAAA);
    rsp_ready = 1'b1;
    for (int k = 0; k < NREG; k++) begin
      @(posedge clk);
      #1;
      check_eq("sweep_we", we, 1'b1);
      check_eq("sweep_rd", rd, k[AW-1:0]);
      check_eq("sweep_data", data_in, 16'h0000);
      check_eq("sweep_init_done", init_done, 1'b0);
      check_eq("sweep_rd_req_ready", rd_req_ready, 1'b0);
      check_eq("sweep_wb_ready", wb_ready, 1'b0);
      check_eq("sweep_rs1", rs1, 5'd0);
      check_eq("sweep_rsp_valid", rsp_valid, 1'b0);
    end
    set_idle();
    @(posedge clk);
    #1;
    check_eq("init_done", init_done, 1'b1);
    check_eq("post_sweep_we", we, 1'b0);
    run_m = 1'b1;
    for (int i = 0; i < NREG; i++) ref_rf[i] = 16'h0000;
    sb.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    run_m  = 1'b0;
    for (int i = 0; i < NREG; i++) ref_rf[i] = 16'h0000;
    rd_src1 = 5'd0; rd_src2 = 5'd0; wb_addr = 5'd0; wb_data = 16'h0000;
    set_idle();
    syn_rst  = 1'b1;
    scramble = 1'b1;
    @(posedge clk);
    #1;
    scramble = 1'b0;
    check_eq("rst_init_done", init_done, 1'b0);
    check_eq("rst_we", we, 1'b0);
    check_eq("rst_rd", rd, 5'd0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_op1", rsp_op1, 16'h0000);
    check_eq("rst_rd_req_ready", rd_req_ready, 1'b0);
    check_eq("rst_wb_ready", wb_ready, 1'b0);
    syn_rst = 1'b0;
    sweep_check();

    // Every register reads back as zero after the sweep.
    for (int i = 0; i < NREG / 2; i++) begin
      rd_req(5'(2 * i), 5'(2 * i + 1));
      step();
    end
    set_idle(); step();

    // Writeback then a later read; r0 operand is zero.
    wb_req(5'd5, 16'h1234); step();
    set_idle(); step(); step(); step();
    rd_req(5'd5, 5'd0); step();
    set_idle(); step();

    // Same-cycle writeback/read, then read while the write is pending.
    wb_req(5'd7, 16'hBEEF); rd_req(5'd7, 5'd5); step();
    wb_valid = 1'b0; rd_req(5'd7, 5'd0); step();
    set_idle(); step();

    // Backpressure: response held for 4 cycles, then drain+accept same edge.
    rd_req(5'd5, 5'd7); step();
    rsp_ready = 1'b0; rd_req(5'd7, 5'd7);
    for (int i = 0; i < 4; i++) step();
    rsp_ready = 1'b1; step();
    set_idle(); step();

    // Writeback to r0 is dropped.
    wb_req(5'd0, 16'hFFFF); step();
    set_idle(); rd_req(5'd0, 5'd0); step();
    set_idle(); step();

    // Consecutive writebacks to one register: last wins.
    wb_req(5'd9, 16'h1111); step();
    wb_req(5'd9, 16'h2222); rd_req(5'd9, 5'd9); step();
    set_idle(); rd_req(5'd9, 5'd3); step();
    set_idle(); step();

    // Random traffic on a small address range to stress forwarding.
    for (int i = 0; i < 300; i++) begin
      wb_valid     = ($urandom_range(0, 1) == 1);
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = 16'($urandom);
      rd_req_valid = ($urandom_range(0, 2) != 0);
      rd_src1      = 5'($urandom_range(0, 7));
      rd_src2      = 5'($urandom_range(0, 7));
      rsp_ready    = ($urandom_range(0, 3) != 0);
      step();
    end
    set_idle(); step();

    // Reset with a held response and a pending write.
    rsp_ready = 1'b0; rd_req(5'd4, 5'd5); step();
    rd_req_valid = 1'b0; wb_req(5'd4, 16'hCAFE); step();
    set_idle();
    syn_rst  = 1'b1;
    scramble = 1'b1;
    @(posedge clk);
    #1;
    scramble = 1'b0;
    check_eq("mid_rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("mid_rst_we", we, 1'b0);
    check_eq("mid_rst_init_done", init_done, 1'b0);
    check_eq("mid_rst_rsp_op1", rsp_op1, 16'h0000);
    syn_rst = 1'b0;
    run_m   = 1'b0;
    sb.delete();
    sweep_check();
    rd_req(5'd4, 5'd5); step();
    set_idle(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
